kbd_rx_ctrl: RTL
================

// Module: kbd_rx_ctrl
// PURPOSE
//   Keyboard input stage upstream of the LC-3 memory/IO device block.
//   - Receives 8N1 asynchronous serial bytes from the keyboard line.
//   - Buffers bytes in a small FIFO.
//   - Presents the FIFO head as the 16-bit KBDR value plus a ready flag that
//     the device uses for KBSR[15].
//   - The device pulses kbdr_rd on every CPU read of KBDR (xFE02); each pulse
//     pops one byte.
// PARAMETERS
//   CLK_DIV     16  clk cycles per serial bit; even, >=4
//   FIFO_DEPTH  4   receive FIFO entries; power of two, >=2
// PORTS
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous reset, active-high
//   rx           in   1   serial keyboard line; idles high; asynchronous to clk
//   kbdr_rd      in   1   one-cycle pulse: CPU read of KBDR; pops FIFO head
//   err_clr      in   1   one-cycle pulse: clears kb_overrun and kb_ferr
//   kbdr         out  16  {8'h00, FIFO head}; 16'h0000 when FIFO is empty
//   kbrdy        out  1   FIFO not empty (drives KBSR[15])
//   kb_overrun   out  1   sticky: a byte was dropped because the FIFO was full
//   kb_ferr      out  1   sticky: a byte was dropped because its stop bit was 0
//   kb_irq       out  1   present only with KBD_IRQ_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, FSM in IDLE, synchroniser flops set to 1.
//   Reset mid-frame abandons the partial byte; no flag is set.
// - rx passes through a 2-flop synchroniser; all logic below uses the
//   synchronised value.
// - RX FSM, with a bit counter and a divider counter (0..CLK_DIV-1):
//   - IDLE:  stay while the line is 1. On 0, go to START and clear the divider.
//   - START: wait CLK_DIV/2 cycles, then resample. If 1, treat it as a glitch
//     and return to IDLE with nothing pushed. If 0, go to DATA.
//   - DATA:  sample every CLK_DIV cycles. 8 samples, LSB first, shifted into
//     the shift register. After the 8th sample, go to STOP.
//   - STOP:  sample after CLK_DIV cycles.
//     - Sample 1 and FIFO not full: push the byte.
//     - Sample 1 and FIFO full: drop the byte and set kb_overrun.
//     - Sample 0: drop the byte and set kb_ferr.
//     - In all cases, next state is IDLE. A new start bit is accepted from the
//       following cycle.
// - Latency: a pushed byte appears on kbdr/kbrdy on the clk edge after the
//   stop-bit sample. A frame takes about 9.5*CLK_DIV cycles from the start edge.
// - FIFO:
//   - kbdr_rd while kbrdy=1 pops the head. kbdr shows the next entry (or
//     16'h0000 if now empty) on the following edge.
//   - kbdr_rd while empty is ignored.
//   - Push and pop in the same cycle: both take effect and the count is
//     unchanged. This holds even when the FIFO is full (the pop frees the slot,
//     so no overrun).
//   - Pointers wrap modulo FIFO_DEPTH.
//   - A count register (0..FIFO_DEPTH) distinguishes full from empty.
// - Sticky flags:
//   - Set by the events above; cleared only by err_clr or rst.
//   - Set and err_clr in the same cycle: set wins.
//   - Error flags never block reception of later bytes.
// CONFIGURATION
// - Macro KBD_IRQ_EN:
//   - Defined: adds input kb_ie (1 bit, the KBSR[14] interrupt enable) and the
//     registered output kb_irq = kb_ie & kbrdy. kb_irq resets to 0 and is
//     updated one cycle after either term changes.
//   - Undefined: neither kb_ie nor kb_irq exists.
//   - All other behaviour is identical with or without the macro.
// TESTING (CLK_DIV=16, FIFO_DEPTH=4)
// 1. Reset, then send byte 8'h41:
//    - Before and during the frame: kbdr=16'h0000, kbrdy=0.
//    - One cycle after the stop sample: kbdr=16'h0041, kbrdy=1.
//    - Pulse kbdr_rd: next cycle kbdr=16'h0000, kbrdy=0.
// 2. Send 8'h31..8'h35 with no reads:
//    - After the 4th byte, the FIFO is full.
//    - The 5th byte is dropped and kb_overrun=1.
//    - Four reads return 16'h0031..16'h0034 in order; kbrdy=0 afterwards.
//    - err_clr clears kb_overrun.
// 3. Send a frame with the stop bit driven 0:
//    - Nothing is pushed, kb_ferr=1.
//    - A following valid 8'h5A is still received: kbdr=16'h005A.
// 4. Pull rx low for 4 cycles only (glitch):
//    - FSM returns to IDLE; kbrdy stays 0; no flags set.
// 5. FIFO holding 4 bytes; assert kbdr_rd in the same cycle as the 5th
//    byte's push:
//    - No overrun; the count stays 4.
//    - The head advances; the 5th byte becomes the tail.
// 6. Assert rst mid-DATA with 2 bytes queued:
//    - All outputs 0 and the FIFO empty immediately.
//    - The next full frame of 8'h7E is received correctly.
//    - With KBD_IRQ_EN defined: kb_ie=1 gives kb_irq=1 one cycle after
//      kbrdy rises.

Source files
------------

// File: rtl/kbd_rx_ctrl_if.sv
// Keyboard receive bus between the device block (master) and kbd_rx_ctrl (slave).
// Optional macro KBD_IRQ_EN adds kb_ie / kb_irq.
interface kbd_rx_ctrl_if;
  logic        rx;
  logic        kbdr_rd;
  logic        err_clr;
  logic [15:0] kbdr;
  logic        kbrdy;
  logic        kb_overrun;
  logic        kb_ferr;
`ifdef KBD_IRQ_EN
  logic        kb_ie;
  logic        kb_irq;

  modport master (output rx, kbdr_rd, err_clr, kb_ie,
                  input  kbdr, kbrdy, kb_overrun, kb_ferr, kb_irq);
  modport slave  (input  rx, kbdr_rd, err_clr, kb_ie,
                  output kbdr, kbrdy, kb_overrun, kb_ferr, kb_irq);
`else
  modport master (output rx, kbdr_rd, err_clr,
                  input  kbdr, kbrdy, kb_overrun, kb_ferr);
  modport slave  (input  rx, kbdr_rd, err_clr,
                  output kbdr, kbrdy, kb_overrun, kb_ferr);
`endif
endinterface

// File: rtl/kbd_rx_ctrl.sv
// 8N1 keyboard receiver with small FIFO presenting KBDR/KBSR[15] to the LC-3 device block.
// Optional macro KBD_IRQ_EN adds the registered kb_irq = kb_ie & kbrdy.
module kbd_rx_ctrl #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  kbd_rx_ctrl_if.slave bus
);
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic            rx_s1_q, rx_s2_q;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            stop_ok, stop_bad;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovr_q, ovr_d, ferr_q, ferr_d;
  logic            full, push, pop, ovr_set;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (!rx_s2_q) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (div_q == DIV_HALF) begin
          div_d   = '0;
          state_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          state_d  = IDLE;
          stop_ok  = rx_s2_q;
          stop_bad = !rx_s2_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  always_comb begin
    full     = (cnt_q == CNT_FULL);
    pop      = bus.kbdr_rd && (cnt_q != '0);
    push     = stop_ok && (!full || pop);
    ovr_set  = stop_ok && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
    ovr_d    = ovr_set  ? 1'b1 : (bus.err_clr ? 1'b0 : ovr_q);
    ferr_d   = stop_bad ? 1'b1 : (bus.err_clr ? 1'b0 : ferr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_s1_q  <= bus.rx;
      rx_s2_q  <= rx_s1_q;
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  // Storage is masked by cnt_q when empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign bus.kbdr       = (cnt_q != '0) ? {8'h00, mem_q[rd_ptr_q]} : '0;
  assign bus.kbrdy      = (cnt_q != '0);
  assign bus.kb_overrun = ovr_q;
  assign bus.kb_ferr    = ferr_q;

`ifdef KBD_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= bus.kb_ie && (cnt_q != '0);
  end
  assign bus.kb_irq = irq_q;
`endif
endmodule
